rsa_decrypt_stream: RTL and testbench



---
 rtl/rsa_decrypt_stream_if.sv | 27 ++
 rtl/rsa_decrypt_stream.sv | 103 ++++++++++
 tb/tb_rsa_decrypt_stream.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_decrypt_stream_if.sv
// Port bundle for rsa_decrypt_stream: key side port, ciphertext in, plaintext out.
// Handshake: a transfer happens on a rising clk edge where valid && ready are both 1.
// A source holds valid and data steady until that edge.
interface rsa_decrypt_stream_if #(parameter int W = 8);
  logic         key_load;
  logic [W-1:0] key_d;
  logic [W-1:0] key_n;
  logic         c_valid;
  logic [W-1:0] c_data;
  logic         c_ready;
  logic         p_valid;
  logic [W-1:0] p_data;
  logic         p_err;
  logic         p_ready;
  logic         busy;
  logic [1:0]   dbg_state;

  modport master (
    output key_load, key_d, key_n, c_valid, c_data, p_ready,
    input  c_ready, p_valid, p_data, p_err, busy, dbg_state
  );

  modport slave (
    input  key_load, key_d, key_n, c_valid, c_data, p_ready,
    output c_ready, p_valid, p_data, p_err, busy, dbg_state
  );
endinterface

// File: rtl/rsa_decrypt_stream.sv
// Byte-serial RSA decryptor: p = c^d mod n via right-to-left square-and-multiply,
// one byte in flight, result held until the consumer takes it.
module rsa_decrypt_stream #(
  parameter int W = 8
) (
  input logic clk,
  input logic rst,
  rsa_decrypt_stream_if.slave bus
);

  typedef enum logic [1:0] {IDLE, INIT, LOOP, DONE} state_t;

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  state_t       state;
  logic [W-1:0] d_reg;
  logic [W-1:0] n_reg;
  logic [W-1:0] c_reg;
  logic [W-1:0] base;
  logic [W-1:0] exp_r;
  logic [W-1:0] acc;
  logic [W-1:0] p_data_r;
  logic         p_err_r;

  // Divisor never drops below 2, so no operator ever sees a zero modulus.
  logic [W-1:0]   n_safe;
  logic [2*W-1:0] n_wide;
  logic [2*W-1:0] acc_prod;
  logic [2*W-1:0] base_prod;
  logic [W-1:0]   acc_next;
  logic [W-1:0]   base_next;
  logic [W-1:0]   base_init;

  assign n_safe    = (n_reg < TWO) ? TWO : n_reg;
  assign n_wide    = {{W{1'b0}}, n_safe};
  assign acc_prod  = {{W{1'b0}}, acc}  * {{W{1'b0}}, base};
  assign base_prod = {{W{1'b0}}, base} * {{W{1'b0}}, base};
  assign acc_next  = W'(acc_prod % n_wide);
  assign base_next = W'(base_prod % n_wide);
  assign base_init = c_reg % n_safe;

  assign bus.c_ready   = (state == IDLE) && !bus.key_load;
  assign bus.p_valid   = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.p_data    = p_data_r;
  assign bus.p_err     = p_err_r;
  assign bus.dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      d_reg    <= '0;
      n_reg    <= '0;
      c_reg    <= '0;
      base     <= '0;
      exp_r    <= '0;
      acc      <= '0;
      p_data_r <= '0;
      p_err_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.key_load) begin
            d_reg <= bus.key_d;
            n_reg <= bus.key_n;
          end else if (bus.c_valid && bus.c_ready) begin
            c_reg <= bus.c_data;
            state <= INIT;
          end
        end
        INIT: begin
          if (n_reg < TWO) begin
            p_data_r <= '0;
            p_err_r  <= 1'b1;
            state    <= DONE;
          end else begin
            base  <= base_init;
            exp_r <= d_reg;
            acc   <= ONE;
            state <= LOOP;
          end
        end
        LOOP: begin
          if (exp_r != '0) begin
            if (exp_r[0]) acc <= acc_next;
            base  <= base_next;
            exp_r <= exp_r >> 1;
          end else begin
            p_data_r <= acc;
            p_err_r  <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (bus.p_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_decrypt_stream.sv
// Bench for rsa_decrypt_stream: directed cases with literal results plus random traffic,
// all cross-checked every cycle against a naive repeated-multiplication model.
module tb_rsa_decrypt_stream;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rsa_decrypt_stream_if #(.W(W)) bus ();

  rsa_decrypt_stream #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int mod_exp(input int c, input int d, input int n);
    int r;
    r = 1;
    for (int i = 0; i < d; i++) r = (r * c) % n;
    return r;
  endfunction

  function automatic int bitlen(input int v);
    int l;
    l = 0;
    while (v != 0) begin
      l++;
      v = v >> 1;
    end
    return l;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [W:0]   exp_q[$];
  logic [W-1:0] md = '0;
  logic [W-1:0] mn = '0;
  logic         in_flight = 1'b0;
  logic         rst_prev = 1'b0;
  logic         armed = 1'b0;
  int           edges = 0;
  int           lat_min = 0;
  int           lat_max = 0;

  always @(negedge clk) begin
    logic         e_err;
    logic [W-1:0] e_data;
    if (rst_prev) armed = 1'b1;
    if (armed) begin
      if (in_flight) edges++;
      if (rst_prev) begin
        chk("rst_p_data", int'(bus.p_data), 0);
        chk("rst_p_err", int'(bus.p_err), 0);
      end
      chk("busy", int'(bus.busy), int'(in_flight));
      chk("c_ready", int'(bus.c_ready), int'(!in_flight && !bus.key_load));
      if (in_flight) begin
        if (edges < lat_min) chk("p_valid_early", int'(bus.p_valid), 0);
        else if (edges >= lat_max) chk("p_valid_due", int'(bus.p_valid), 1);
        if (bus.p_valid && exp_q.size() > 0) begin
          chk("p_data", int'(bus.p_data), int'(exp_q[0][W-1:0]));
          chk("p_err", int'(bus.p_err), int'(exp_q[0][W]));
        end
      end else begin
        chk("p_valid_idle", int'(bus.p_valid), 0);
      end
      // Model the transfer that the coming rising edge will perform.
      if (in_flight) begin
        if (bus.p_valid && bus.p_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          in_flight = 1'b0;
        end
      end else if (bus.key_load) begin
        md = bus.key_d;
        mn = bus.key_n;
      end else if (bus.c_valid) begin
        e_err  = (mn < 2);
        e_data = e_err ? '0 : W'(mod_exp(int'(bus.c_data), int'(md), int'(mn)));
        exp_q.push_back({e_err, e_data});
        if (e_err) begin
          lat_min = 1;
          lat_max = 2;
        end else begin
          lat_min = bitlen(int'(md)) + 2;
          lat_max = lat_min;
        end
        edges     = -1;
        in_flight = 1'b1;
      end
    end
    if (rst) begin
      md = '0;
      mn = '0;
      in_flight = 1'b0;
      exp_q.delete();
    end
    rst_prev = rst;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input int d, input int n);
    bus.key_load = 1'b1;
    bus.key_d    = W'(d);
    bus.key_n    = W'(n);
    tick();
    bus.key_load = 1'b0;
  endtask

  task automatic start_byte(input int c);
    int n;
    bus.c_valid = 1'b1;
    bus.c_data  = W'(c);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.c_ready) break;
      n++;
      if (n > 200) begin
        chk("c_handshake_timeout", 0, 1);
        break;
      end
    end
    tick();
    bus.c_valid = 1'b0;
  endtask

  task automatic send_byte(input int c, input int hold,
                           output int got_d, output int got_e, output int lat);
    int n;
    bus.p_ready = (hold == 0);
    start_byte(c);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.p_valid) break;
      n++;
      if (n > 400) begin
        chk("p_valid_timeout", 0, 1);
        break;
      end
    end
    lat   = n;
    got_d = int'(bus.p_data);
    got_e = int'(bus.p_err);
    if (hold > 0) begin
      repeat (hold) begin
        tick();
        bus.c_valid = 1'($urandom_range(0, 1));
        bus.c_data  = W'($urandom);
      end
      bus.c_valid = 1'b0;
      bus.p_ready = 1'b1;
    end
    tick();
    bus.p_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int gd, ge, gl;

  initial begin
    bus.key_load = 1'b0;
    bus.key_d    = '0;
    bus.key_n    = '0;
    bus.c_valid  = 1'b0;
    bus.c_data   = '0;
    bus.p_ready  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_p_valid", int'(bus.p_valid), 0);
    chk("reset_c_ready", int'(bus.c_ready), 1);
    chk("reset_busy", int'(bus.busy), 0);
    tick();

    load_key(7, 33);
    send_byte(31, 0, gd, ge, gl);
    chk("d7_data", gd, 4);
    chk("d7_err", ge, 0);
    chk("d7_lat", gl, 5);
    @(negedge clk);
    chk("d7_c_ready_after", int'(bus.c_ready), 1);
    tick();

    load_key(23, 187);
    send_byte(11, 0, gd, ge, gl);
    chk("d23_data", gd, 88);
    chk("d23_lat", gl, 7);
    load_key(1, 187);
    send_byte(200, 0, gd, ge, gl);
    chk("reduce_data", gd, 13);
    chk("reduce_lat", gl, 3);

    load_key(7, 33);
    send_byte(31, 10, gd, ge, gl);
    chk("bp_data", gd, 4);

    load_key(0, 33);
    send_byte(5, 0, gd, ge, gl);
    chk("d0_data", gd, 1);
    chk("d0_lat", gl, 2);
    load_key(7, 1);
    send_byte(5, 0, gd, ge, gl);
    chk("n1_data", gd, 0);
    chk("n1_err", ge, 1);
    load_key(7, 0);
    send_byte(200, 2, gd, ge, gl);
    chk("n0_data", gd, 0);
    chk("n0_err", ge, 1);

    load_key(7, 33);
    fork
      send_byte(31, 0, gd, ge, gl);
      begin
        repeat (3) tick();
        bus.key_load = 1'b1;
        bus.key_d    = W'(23);
        bus.key_n    = W'(187);
        tick();
        bus.key_load = 1'b0;
      end
    join
    chk("keyload_loop_data", gd, 4);
    load_key(23, 187);
    send_byte(11, 0, gd, ge, gl);
    chk("keyload_idle_data", gd, 88);

    load_key(23, 187);
    start_byte(11);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_p_valid", int'(bus.p_valid), 0);
    chk("midrst_p_data", int'(bus.p_data), 0);
    chk("midrst_c_ready", int'(bus.c_ready), 1);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_d_reg", int'(dut.d_reg), 0);
    chk("midrst_n_reg", int'(dut.n_reg), 0);
    tick();
    send_byte(11, 0, gd, ge, gl);
    chk("midrst_err", ge, 1);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 7) == 0) load_key($urandom_range(0, 255), $urandom_range(0, 1));
        else load_key($urandom_range(0, 255), $urandom_range(2, 255));
      end
      send_byte($urandom_range(0, 255), $urandom_range(0, 3), gd, ge, gl);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
